// File: rtl/sha2_uart_sequencer_if.sv
// sha2_uart_sequencer_if: groups the UART rx/tx, SHA-256 core and status signals of the sequencer.
// master: the sequencer (drives tx_*, core_we/idx/word/start, status); slave: the UART/core side.
interface sha2_uart_sequencer_if;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         rx_error;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_busy;
  logic         core_we;
  logic [3:0]   core_idx;
  logic [31:0]  core_word;
  logic         core_start;
  logic         core_busy;
  logic         core_done;
  logic [255:0] core_digest;
  logic [7:0]   status;
  modport master (
    input  rx_valid, rx_byte, rx_error, tx_busy, core_busy, core_done, core_digest,
    output tx_start, tx_byte, core_we, core_idx, core_word, core_start, status
  );
  modport slave (
    output rx_valid, rx_byte, rx_error, tx_busy, core_busy, core_done, core_digest,
    input  tx_start, tx_byte, core_we, core_idx, core_word, core_start, status
  );
endinterface

// File: rtl/sha2_uart_sequencer.sv
// sha2_uart_sequencer: loads 64 UART bytes into a SHA-256 core, hashes them and streams the 32-byte digest back out.
// Ports: clk, rst (async active-high), bus (sha2_uart_sequencer_if.master: rx/tx UART, core write/start/done, status LEDs).
// Optional SHA2_RXERR_ABORT_EN: rx_error while loading discards the partial block.
module sha2_uart_sequencer #(
  parameter logic [31:0] RX_TIMEOUT = 32'd50_000_000
) (
  input logic clk,
  input logic rst,
  sha2_uart_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, HASH, SEND, SEND_WAIT} state_t;
  state_t state, state_n;
  logic [5:0]   cnt;
  logic [23:0]  sr;
  logic [31:0]  tmo;
  logic [255:0] digest;
  logic [4:0]   bidx;
  logic [1:0]   wcnt;
  logic take, tmo_hit, abort, ovr, send_go, wait_go, done_all;
  logic [3:0] st_n;
  always_comb begin
    // a byte flagged with a framing error is never accepted
    take = bus.rx_valid && !bus.rx_error && (state == IDLE || state == LOAD);
    ovr = bus.rx_valid && !(state == IDLE || state == LOAD);
    tmo_hit = state == LOAD && !take && tmo == RX_TIMEOUT - 32'd1;
`ifdef SHA2_RXERR_ABORT_EN
    abort = state == LOAD && bus.rx_error;
`else
    abort = 1'b0;
`endif
    send_go = state == SEND && !bus.tx_busy;
    wait_go = state == SEND_WAIT && wcnt == 2'd2 && !bus.tx_busy;
    done_all = wait_go && bidx == 5'd31;
    state_n = state;
    unique case (state)
      IDLE:      state_n = take ? LOAD : IDLE;
      LOAD:      state_n = (abort || tmo_hit) ? IDLE : (take && cnt == 6'd63) ? START : LOAD;
      START:     state_n = bus.core_busy ? START : HASH;
      HASH:      state_n = bus.core_done ? SEND : HASH;
      SEND:      state_n = send_go ? SEND_WAIT : SEND;
      SEND_WAIT: state_n = wait_go ? (bidx == 5'd31 ? IDLE : SEND) : SEND_WAIT;
      default:   state_n = IDLE;
    endcase
    st_n = {state_n == SEND || state_n == SEND_WAIT, state_n == START || state_n == HASH,
            state_n == LOAD, state_n == IDLE};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      tmo <= '0;
      digest <= '0;
      bidx <= '0;
      wcnt <= '0;
      bus.core_we <= 1'b0;
      bus.core_idx <= '0;
      bus.core_word <= '0;
      bus.core_start <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_byte <= '0;
      bus.status <= '0;
    end else begin
      bus.core_we <= 1'b0;
      bus.core_start <= 1'b0;
      bus.tx_start <= 1'b0;
      if (take) begin
        cnt <= cnt + 6'd1;
        sr <= {sr[15:0], bus.rx_byte};
        tmo <= '0;
        if (cnt[1:0] == 2'd3) begin
          bus.core_we <= 1'b1;
          bus.core_idx <= cnt[5:2];
          bus.core_word <= {sr, bus.rx_byte};
        end
      end else if (state == LOAD) tmo <= tmo + 32'd1;
      if (abort || tmo_hit) begin
        cnt <= '0;
        tmo <= '0;
      end
      if (state == START && !bus.core_busy) bus.core_start <= 1'b1;
      if (state == HASH && bus.core_done) begin
        digest <= bus.core_digest;
        bidx <= '0;
      end
      if (send_go) begin
        // byte i of the digest sits at [255-8i -: 8]; ~bidx is 31-i
        bus.tx_byte <= digest[{~bidx, 3'b111} -: 8];
        bus.tx_start <= 1'b1;
        wcnt <= '0;
      end
      if (state == SEND_WAIT && wcnt != 2'd2) wcnt <= wcnt + 2'd1;
      if (wait_go) bidx <= bidx + 5'd1;
      if (done_all) cnt <= '0;
      bus.status <= {bus.status[7] ^ done_all, bus.status[6] | tmo_hit,
                     bus.status[5] | bus.rx_error, bus.status[4] | ovr, st_n};
    end
  end
endmodule

// File: tb/tb_sha2_uart_sequencer.sv
// tb_sha2_uart_sequencer: scoreboard bench for sha2_uart_sequencer with a UART busy model and a hand-driven core.
module tb_sha2_uart_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sha2_uart_sequencer_if bus();
  sha2_uart_sequencer #(.RX_TIMEOUT(32'd100)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  logic [35:0] exp_we[$];
  logic [7:0]  exp_tx[$];
  int exp_starts = 0, starts_seen = 0, tx_seen = 0, busy_cnt = 0;
  logic [7:0] last_tx = '0;
  logic [255:0] dg = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  assign bus.tx_busy = busy_cnt != 0;
  always @(posedge clk or posedge rst)
    if (rst) busy_cnt <= 0;
    else if (bus.tx_start) busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  always @(negedge clk) if (!rst) begin
    if (bus.core_we) begin
      if (exp_we.size() == 0) begin
        checks++; failures++;
        $display("FAIL core_we_unexpected: got idx %0d word %h expected none", bus.core_idx, bus.core_word);
      end else chk("core_we", {bus.core_idx, bus.core_word}, exp_we.pop_front());
    end
    if (bus.core_start) begin
      starts_seen++;
      checks++;
      if (exp_starts == 0) begin
        failures++;
        $display("FAIL core_start_unexpected: got pulse expected none");
      end else exp_starts--;
    end
    if (bus.tx_start) begin
      tx_seen++;
      last_tx = bus.tx_byte;
      chk("tx_busy_at_start", bus.tx_busy, 0);
      if (exp_tx.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_start_unexpected: got byte %h expected none", bus.tx_byte);
      end else chk("tx_byte", bus.tx_byte, exp_tx.pop_front());
    end else if (bus.tx_busy) chk("tx_byte_hold", bus.tx_byte, last_tx);
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_bytes(input logic [7:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(base + 8'(i));
  endtask
  task automatic push_words(input logic [7:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      logic [7:0] b0;
      logic [3:0] idx;
      b0 = base + 8'(4 * k);
      idx = 4'(k);
      exp_we.push_back({idx, b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
    end
  endtask
  task automatic push_tx(input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(dg[255 - 8 * i -: 8]);
  endtask
  task automatic wait_starts(input int target);
    for (int i = 0; i < 500 && starts_seen < target; i++) @(negedge clk);
    chk("core_start_seen", starts_seen, target);
  endtask
  task automatic pulse_done();
    @(negedge clk);
    bus.core_done = 1'b1;
    bus.core_digest = dg;
    @(negedge clk);
    bus.core_done = 1'b0;
    bus.core_busy = 1'b0;
    bus.core_digest = '0;
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte = '0;
    bus.rx_error = 1'b0;
    bus.core_busy = 1'b0;
    bus.core_done = 1'b0;
    bus.core_digest = '0;
    repeat (3) @(negedge clk);
    chk("reset_status", bus.status, 8'h00);
    chk("reset_tx_start", bus.tx_start, 0);
    chk("reset_core_we", bus.core_we, 0);
    chk("reset_core_start", bus.core_start, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("status_idle", bus.status, 8'h01);
    // full block 0x00..0x3F, overrun during HASH, digest send
    push_words(8'h00, 0, 15);
    exp_starts++;
    send_bytes(8'h00, 0, 63);
    wait_starts(1);
    chk("status_hash", bus.status, 8'h04);
    bus.core_busy = 1'b1;
    repeat (3) send_byte(8'hEE);
    chk("status_overrun", bus.status, 8'h14);
    push_tx(32);
    pulse_done();
    for (int i = 0; i < 3000 && !bus.status[0]; i++) @(negedge clk);
    chk("tx_count_full", tx_seen, 32);
    chk("status_after_send", bus.status, 8'h91);
    // partial block then idle timeout
    push_words(8'hA0, 0, 1);
    send_bytes(8'hA0, 0, 9);
    repeat (99) @(negedge clk);
    chk("status_before_timeout", bus.status, 8'h92);
    @(negedge clk);
    chk("status_timeout", bus.status, 8'hD1);
    push_words(8'h40, 0, 15);
    exp_starts++;
    send_bytes(8'h40, 0, 63);
    wait_starts(2);
    bus.core_busy = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(20);
    pulse_done();
    for (int i = 0; i < 3000 && tx_seen < 52; i++) @(negedge clk);
    chk("tx_count_before_rst", tx_seen, 52);
    rst = 1'b1;
    #1;
    chk("rst_status", bus.status, 8'h00);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 8'h00);
    chk("rst_core_word", bus.core_word, 32'h0);
    chk("rst_core_idx", bus.core_idx, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("tx_count_after_rst", tx_seen, 52);
    chk("status_after_rst", bus.status, 8'h01);
    // framing error after 8 bytes
    push_words(8'h10, 0, 1);
    send_bytes(8'h10, 0, 7);
    @(negedge clk);
    bus.rx_error = 1'b1;
    @(negedge clk);
    bus.rx_error = 1'b0;
`ifdef SHA2_RXERR_ABORT_EN
    chk("status_rxerr_abort", bus.status, 8'h21);
`else
    chk("status_rxerr_load", bus.status, 8'h22);
    push_words(8'h10, 2, 15);
    exp_starts++;
    send_bytes(8'h10, 8, 63);
    wait_starts(3);
    chk("status_rxerr_block", bus.status, 8'h24);
`endif
    repeat (5) @(negedge clk);
    chk("we_queue_empty", exp_we.size(), 0);
    chk("start_pending", exp_starts, 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha2_uart_sequencer.md
SHA2_UART_SEQUENCER -- requirements
Module: sha2_uart_sequencer

Interface
REQ-001 SHALL have parameter RX_TIMEOUT, default 32'd50_000_000, meaning max idle clk cycles between bytes of a partially loaded block.
REQ-002 SHALL have ports: clk  in  1  master clock, all logic rising-edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rx_valid  in  1  one-cycle pulse from UART, byte received.
REQ-005 rx_byte  in  8  received byte, valid with rx_valid.
REQ-006 rx_error  in  1  one-cycle pulse, UART framing error.
REQ-007 tx_start  out  1  one-cycle pulse to UART, start transmitting tx_byte.
REQ-008 tx_byte  out  8  byte to transmit, held stable from tx_start until tx_busy falls.
REQ-009 tx_busy  in  1  UART transmitting.
REQ-010 core_we  out  1  one-cycle message-word write strobe to SHA-256 core.
REQ-011 core_idx  out  4  word index 0..15 for core_we.
REQ-012 core_word  out  32  message word for core_we.
REQ-013 core_start  out  1  one-cycle pulse, hash the loaded block.
REQ-014 core_busy  in  1  core hashing.
REQ-015 core_done  in  1  one-cycle pulse, core_digest valid this cycle.
REQ-016 core_digest  in  256  digest, H0 in [255:224].
REQ-017 status  out  8  LED status vector.

Function
REQ-018 States: IDLE, LOAD, START, HASH, SEND, SEND_WAIT; one state register.
REQ-019 IDLE: first rx_valid stores byte 0, goes to LOAD; byte counter 0..63 increments per accepted byte.
REQ-020 Bytes packed big-endian: byte 4k is core_word[31:24] of word k, byte 4k+3 is [7:0].
REQ-021 Cycle after 4th byte of word k: core_we=1, core_idx=k, core_word=assembled word, for exactly one cycle.
REQ-022 After 64th byte and word-15 write: go to START; core_start pulses one cycle first cycle core_busy=0, then HASH.
REQ-023 HASH: on core_done latch core_digest into 256-bit register, go to SEND with byte index 0.
REQ-024 SEND: when tx_busy=0, drive tx_byte=digest byte i (byte 0 = [255:248]), pulse tx_start, go to SEND_WAIT.
REQ-025 SEND_WAIT: wait at least 2 cycles and tx_busy=0, then i+1 to SEND; after byte 31 go to IDLE, clear byte counter.
REQ-026 rx_valid in START, HASH, SEND, SEND_WAIT: byte dropped, overrun sticky set; no state change.
REQ-027 LOAD: RX_TIMEOUT cycles with no rx_valid discard partial block, set timeout sticky, return IDLE; counter reloads on every byte.
REQ-028 rx_valid and timeout expiry same cycle: byte wins, timeout not taken.
REQ-029 status[0]=IDLE, [1]=LOAD, [2]=START or HASH, [3]=SEND or SEND_WAIT, [4]=overrun sticky, [5]=rx_error sticky, [6]=timeout sticky, [7] toggles per completed 32-byte digest send.
REQ-030 Sticky bits cleared only by rst.

Reset
REQ-031 rst asserted at any time, incl. mid-block or mid-send: immediately state IDLE, counters 0, digest register 0, status 0, tx_start/core_we/core_start 0, tx_byte/core_word/core_idx 0.
REQ-032 Partial block or digest in progress at reset is lost; no further output pulses until new bytes arrive after rst deasserts.

Configuration
REQ-033 Macro SHA2_RXERR_ABORT_EN defined: rx_error in LOAD discards partial block, returns IDLE, sets status[5].
REQ-034 Macro not defined: rx_error only sets status[5]; erroneous byte not accepted; loading continues.

Verification
REQ-035 64 bytes 0x00..0x3F -> 16 core_we pulses, word0=0x00010203, word15=0x3C3D3E3F, then one core_start.
REQ-036 core_done with digest 0xBA7816BF...15AD -> 32 tx_start pulses, first tx_byte 0xBA, last 0xAD, each after tx_busy low; status[7] toggles.
REQ-037 10 bytes then RX_TIMEOUT (bench 100) idle cycles -> IDLE, status[6]=1, next 64 bytes form clean block (word0 from new byte 0).
REQ-038 rx_valid pulses during HASH -> no core_we, status[4]=1, digest output unaffected.
REQ-039 rst pulse after 20th digest byte sent -> all outputs 0 within same cycle, no further tx_start.
REQ-040 rx_error after 8 bytes: with SHA2_RXERR_ABORT_EN -> IDLE, status[5]=1; without -> remains LOAD, status[5]=1, 56 more bytes complete block.
